// File: rtl/gx_command_processor.sv
// gx_command_processor
//   Pulls opcodes and operands from the byte-granular command deserializer and
//   dispatches them to the XF load bus (0x10), the CP register bus (0x08) and
//   the BP bus (0x61). 0x00 is a NOP. Any other opcode raises a sticky error.
//
// Handshake (command side): in a fetch state cmd_req=1 with a fixed cmd_bytes
//   until cmd_valid arrives. cmd_valid is a one-cycle pulse and is consumed on
//   the cycle it is high. A cmd_valid outside a fetch state is ignored.
// Handshake (XF side): xf_write is held with stable xf_addr/xf_data until the
//   cycle where xf_write && xf_ready; that cycle transfers the word.
//
// Ports
//   clk, resetn                 clock, asynchronous active-low reset
//   cmd_req/cmd_bytes           operand request (1, 2 or 4 bytes; 0 when idle)
//   cmd_valid/cmd_data          operand return, MSB-aligned
//   xf_addr/xf_data/xf_write    XF word write, xf_ready back-pressure
//   cp_reg_addr/cp_reg_data     CP register write, cp_reg_write one-cycle strobe
//   bp_data/bp_write            BP command word, one-cycle strobe
//   err_valid/err_opcode        sticky unknown-opcode flag and first bad opcode
//   err_clear                   clears err_valid and leaves HALT
//   busy                        high in every state except OP_GET
//   dbg_state                   current FSM state
module gx_command_processor #(
  parameter int XF_ADDR_WIDTH = 16,
  parameter int XF_LEN_BITS   = 16,
  parameter int ERR_HALT      = 0
) (
  input  logic                     clk,
  input  logic                     resetn,
  output logic                     cmd_req,
  output logic [2:0]               cmd_bytes,
  input  logic                     cmd_valid,
  input  logic [31:0]              cmd_data,
  output logic [XF_ADDR_WIDTH-1:0] xf_addr,
  output logic [31:0]              xf_data,
  output logic                     xf_write,
  input  logic                     xf_ready,
  output logic [7:0]               cp_reg_addr,
  output logic [31:0]              cp_reg_data,
  output logic                     cp_reg_write,
  output logic [31:0]              bp_data,
  output logic                     bp_write,
  output logic                     err_valid,
  output logic [7:0]               err_opcode,
  input  logic                     err_clear,
  output logic                     busy,
  output logic [3:0]               dbg_state
);

  typedef enum logic [3:0] {
    S_OP_GET, S_XF_SZ, S_XF_ADR, S_XF_DAT, S_XF_WR,
    S_CP_ADR, S_CP_DAT, S_CP_WR, S_BP_DAT, S_BP_WR, S_HALT
  } state_t;

  localparam logic [XF_ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [XF_LEN_BITS-1:0]   CNT_ONE  = 1;

  state_t                   r_state;
  logic [XF_LEN_BITS-1:0]   r_count;
  logic [XF_ADDR_WIDTH-1:0] r_xf_addr;
  logic [31:0]              r_xf_data;
  logic                     r_xf_write;
  logic [7:0]               r_cp_reg_addr;
  logic [31:0]              r_cp_reg_data;
  logic                     r_cp_reg_write;
  logic [31:0]              r_bp_data;
  logic                     r_bp_write;
  logic                     r_err_valid;
  logic [7:0]               r_err_opcode;

  logic       w_fetch;
  logic [2:0] w_bytes;
  logic [7:0] w_opcode;
  logic       w_known;
  logic       w_new_err;

  assign w_opcode = cmd_data[31:24];
  assign w_known  = (w_opcode == 8'h10) || (w_opcode == 8'h08) ||
                    (w_opcode == 8'h61) || (w_opcode == 8'h00);
  assign w_new_err = (r_state == S_OP_GET) && cmd_valid && !w_known;

  // Operand width requested by each fetch state.
  always_comb begin
    w_fetch = 1'b1;
    w_bytes = 3'd0;
    case (r_state)
      S_OP_GET, S_CP_ADR:          w_bytes = 3'd1;
      S_XF_SZ, S_XF_ADR:           w_bytes = 3'd2;
      S_XF_DAT, S_CP_DAT, S_BP_DAT: w_bytes = 3'd4;
      default:                     w_fetch = 1'b0;
    endcase
  end

  assign cmd_req   = w_fetch && !cmd_valid;
  assign cmd_bytes = cmd_req ? w_bytes : 3'd0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state        <= S_OP_GET;
      r_count        <= '0;
      r_xf_addr      <= '0;
      r_xf_data      <= '0;
      r_xf_write     <= 1'b0;
      r_cp_reg_addr  <= '0;
      r_cp_reg_data  <= '0;
      r_cp_reg_write <= 1'b0;
      r_bp_data      <= '0;
      r_bp_write     <= 1'b0;
      r_err_valid    <= 1'b0;
      r_err_opcode   <= '0;
    end else begin
      // A new error beats a simultaneous clear; the clear lets it be captured.
      if (w_new_err) begin
        r_err_valid <= 1'b1;
        if (!r_err_valid || err_clear) r_err_opcode <= w_opcode;
      end else if (err_clear) begin
        r_err_valid <= 1'b0;
      end

      case (r_state)
        S_OP_GET: begin
          if (cmd_valid) begin
            case (w_opcode)
              8'h10:   r_state <= S_XF_SZ;
              8'h08:   r_state <= S_CP_ADR;
              8'h61:   r_state <= S_BP_DAT;
              8'h00:   r_state <= S_OP_GET;
              default: r_state <= (ERR_HALT != 0) ? S_HALT : S_OP_GET;
            endcase
          end
        end
        S_XF_SZ: begin
          if (cmd_valid) begin
            // Counter holds words-remaining-minus-one.
            r_count <= cmd_data[16 +: XF_LEN_BITS];
            r_state <= S_XF_ADR;
          end
        end
        S_XF_ADR: begin
          if (cmd_valid) begin
            r_xf_addr <= cmd_data[16 +: XF_ADDR_WIDTH];
            r_state   <= S_XF_DAT;
          end
        end
        S_XF_DAT: begin
          if (cmd_valid) begin
            r_xf_data  <= cmd_data;
            r_xf_write <= 1'b1;
            r_state    <= S_XF_WR;
          end
        end
        S_XF_WR: begin
          if (xf_ready) begin
            r_xf_write <= 1'b0;
            r_xf_addr  <= r_xf_addr + ADDR_ONE;
            if (r_count == '0) begin
              r_state <= S_OP_GET;
            end else begin
              r_count <= r_count - CNT_ONE;
              r_state <= S_XF_DAT;
            end
          end
        end
        S_CP_ADR: begin
          if (cmd_valid) begin
            r_cp_reg_addr <= cmd_data[31:24];
            r_state       <= S_CP_DAT;
          end
        end
        S_CP_DAT: begin
          if (cmd_valid) begin
            r_cp_reg_data  <= cmd_data;
            r_cp_reg_write <= 1'b1;
            r_state        <= S_CP_WR;
          end
        end
        S_CP_WR: begin
          r_cp_reg_write <= 1'b0;
          r_state        <= S_OP_GET;
        end
        S_BP_DAT: begin
          if (cmd_valid) begin
            r_bp_data  <= cmd_data;
            r_bp_write <= 1'b1;
            r_state    <= S_BP_WR;
          end
        end
        S_BP_WR: begin
          r_bp_write <= 1'b0;
          r_state    <= S_OP_GET;
        end
        S_HALT: begin
          if (err_clear) r_state <= S_OP_GET;
        end
        default: r_state <= S_OP_GET;
      endcase
    end
  end

  assign xf_addr      = r_xf_addr;
  assign xf_data      = r_xf_data;
  assign xf_write     = r_xf_write;
  assign cp_reg_addr  = r_cp_reg_addr;
  assign cp_reg_data  = r_cp_reg_data;
  assign cp_reg_write = r_cp_reg_write;
  assign bp_data      = r_bp_data;
  assign bp_write     = r_bp_write;
  assign err_valid    = r_err_valid;
  assign err_opcode   = r_err_opcode;
  assign busy         = (r_state != S_OP_GET);
  assign dbg_state    = r_state;

endmodule
